// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: run/pause/clear sequencer for a cascaded BCD counter chain.
// A prescaler divides the clock; every PRESCALE cycles in RUN the chain
// advances by one, with decade carries between digits. Reaching the BCD
// limit (or the full wrap when limit is zero) pulses done and stops in DONE.
// Optional feature macro: BCD_CTRL_AUTO_RELOAD_EN -- when defined, the
// terminal count reloads to zero and the controller keeps running.
//
// Control inputs are level-sampled on every rising clk edge; there is no
// valid/ready handshake. Priority is clear > pause > start.
// pause has an effect only in RUN. start has an effect in IDLE, PAUSE and DONE.
module bcd_count_ctrl #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   count,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t          state_q, state_n;
    logic [W-1:0]    count_q, count_n;
    logic [PW-1:0]   ps_q, ps_n;
    logic            done_q, done_n;

    logic [W-1:0]    inc_count;
    logic            wrap;
    logic            carry;
    logic [3:0]      digit;
    logic            limit_ok;
    logic            terminal;

    // Decade increment of the whole chain; a digit at 9 (or above) with a
    // carry-in always goes to 0 so only 0..9 is ever produced.
    always_comb begin
        inc_count = '0;
        carry     = 1'b1;
        digit     = '0;
        for (int d = 0; d < DIGITS; d++) begin
            digit = count_q[4*d +: 4];
            if (carry) begin
                if (digit >= 4'd9) begin
                    inc_count[4*d +: 4] = 4'd0;
                    carry               = 1'b1;
                end else begin
                    inc_count[4*d +: 4] = digit + 4'd1;
                    carry               = 1'b0;
                end
            end else begin
                inc_count[4*d +: 4] = digit;
            end
        end
        wrap = carry;
    end

    // Terminal detection: zero limit means full wrap; a limit with any
    // non-decimal digit can never match.
    always_comb begin
        limit_ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (limit[4*d +: 4] > 4'd9) begin
                limit_ok = 1'b0;
            end
        end
        if (limit == '0) begin
            terminal = wrap;
        end else begin
            terminal = limit_ok && (inc_count == limit);
        end
    end

    // Next-state, next-count and prescaler logic.
    always_comb begin
        state_n = state_q;
        count_n = count_q;
        ps_n    = ps_q;
        done_n  = 1'b0;
        if (clear) begin
            state_n = IDLE;
            count_n = '0;
            ps_n    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_n = RUN;
                        ps_n    = '0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_n = PAUSE;
                    end else if (ps_q == PS_LAST) begin
                        ps_n    = '0;
                        count_n = inc_count;
                        if (terminal) begin
                            done_n = 1'b1;
`ifdef BCD_CTRL_AUTO_RELOAD_EN
                            count_n = '0;
`else
                            state_n = DONE;
`endif
                        end
                    end else begin
                        ps_n = ps_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_n = RUN;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_n = RUN;
                        count_n = '0;
                        ps_n    = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, count, prescaler and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            ps_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            ps_q    <= ps_n;
            done_q  <= done_n;
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Sequencing controller for a cascaded BCD (decade, 0-9) counter chain of DIGITS digits. It runs, pauses and clears the chain on control pulses, and divides the clock with a prescaler. Each digit steps 0..9 and wraps with a carry into the next digit. Terminal detection against a BCD limit produces a done pulse. It sits between the front-panel/control logic and the digit registers and display decode.

Parameters:
DIGITS, 2, number of cascaded BCD digits (1..4); count width is 4*DIGITS.
PRESCALE, 4, clock cycles per count increment while RUN (>=1; 1 = increment every cycle).

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
start  input  1  level-sampled request: IDLE/PAUSE/DONE -> RUN.
pause  input  1  level-sampled request: RUN -> PAUSE.
clear  input  1  level-sampled request: any state -> IDLE, count zeroed.
limit  input  4*DIGITS  BCD terminal value, digit 0 in bits [3:0].
count  output  4*DIGITS  current BCD count, digit 0 in bits [3:0].
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
busy  output  1  1 exactly when state == RUN.
done  output  1  one-cycle pulse on terminal count.

Behaviour:
- Reset (rst_n=0 at an edge): count=0, state=IDLE, busy=0, done=0, prescaler=0. Applies mid-operation from any state. Control inputs are ignored during that cycle.
- Control priority per cycle: clear > pause > start.
- IDLE: start -> RUN next cycle, prescaler=0, count unchanged (0).
- RUN: prescaler increments each cycle. When prescaler==PRESCALE-1, prescaler->0 and count increments at that edge. The first increment therefore lands PRESCALE cycles after entry to RUN. pause -> PAUSE with no increment that cycle, even if the prescaler was at terminal. start while RUN is ignored.
- PAUSE: count and prescaler frozen. start -> RUN and resumes from the held prescaler value. pause is ignored.
- DONE: count held at the terminal value. start -> RUN with count=0 and prescaler=0.
- clear in any state: next state IDLE, count=0, prescaler=0, done=0.
- Increment rule:
  - Digit 0 +1; any digit at 9 with carry-in -> 0 and carries out.
  - All digits at 9 -> all 0 (full wrap).
  - Digits never hold values >9. The internal next-digit logic must only produce 0..9.
- Terminal:
  - If the post-increment count == limit and limit != 0: state -> DONE, done=1 for exactly that edge's following cycle, busy=0.
  - limit == 0: terminal is the full wrap (all-9s -> 0).
  - A limit with any digit >9 never matches: the counter free-runs and done is never asserted.
  - limit is sampled only at increment edges, so changing it mid-run takes effect at the next increment.
- Simultaneous events: clear on the terminal-increment cycle wins (IDLE, count=0, no done). pause on the terminal-prescaler cycle wins (PAUSE, no increment).
- busy and done are registered, with no combinational path from inputs.

Optional Feature:
BCD_CTRL_AUTO_RELOAD_EN
- Defined: on terminal, count -> 0 in the same edge and state stays RUN (busy stays 1). done still pulses one cycle. DONE state (11) is unreachable.
- Undefined: behaviour as above (stop in DONE, hold terminal count).

Test Plan (DIGITS=2, PRESCALE=4 unless noted):
1. Reset and start: rst_n low 2 cycles -> count=0x00, state=00, done=0. Pulse start -> state=01 next cycle, count=0x01 exactly 4 cycles after RUN entry, 0x02 4 cycles later.
2. BCD carry: run from 0x00 -> sequence ..., 0x09, 0x10, ..., 0x19, 0x20. Count never shows a nibble >9. With limit=0, 0x99 -> 0x00 pulses done once and state=11.
3. Terminal limit: limit=0x12, start -> count reaches 0x12, done=1 for one cycle, state=11, count holds 0x12 for 20 cycles. Start -> state=01, count=0x00.
4. Pause/resume: pause 2 cycles into a prescale period at count 0x05 -> frozen 10 cycles. start -> count=0x06 exactly 2 cycles after resume.
5. Priority/corner cases:
   - clear+pause+start on the same cycle in RUN -> IDLE, count=0x00.
   - clear on the terminal cycle -> no done pulse.
   - rst_n low mid-RUN at 0x37 -> 0x00/IDLE next edge.
6. With BCD_CTRL_AUTO_RELOAD_EN and limit=0x03, PRESCALE=1: count 1,2,3->0,1,... Done pulses every 3rd increment, and state stays 01.
